// File: rtl/simd_arith_pipe_pkg.sv
// Shared definitions for the SIMD arithmetic pipeline: opcodes and saturation bounds.
package simd_arith_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_MAC = 4'b0011,
    OP_MAX = 4'b0101,
    OP_MIN = 4'b0110,
    OP_ASR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_NOT = 4'b1100,
    OP_AND = 4'b1101,
    OP_OR  = 4'b1110,
    OP_XOR = 4'b1111
  } op_e;

  localparam int MAX_WIDTH = 64;

  // Most positive / most negative two's-complement value of a given width.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/simd_lane_sat.sv
// One SIMD lane: full-width product for stage 1, and the saturating result plus
// overflow/underflow detection for stage 2. Purely combinational.
module simd_lane_sat
  import simd_arith_pipe_pkg::*;
#(
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic signed [BIT_WIDTH-1:0]   mul_a,
  input  logic signed [BIT_WIDTH-1:0]   mul_b,
  output logic [2*BIT_WIDTH-1:0]        product,
  input  logic [FUNCTION_BITS-1:0]      fn,
  input  logic [7:0]                    frac,
  input  logic                          en,
  input  logic signed [BIT_WIDTH-1:0]   a,
  input  logic signed [BIT_WIDTH-1:0]   b,
  input  logic signed [BIT_WIDTH-1:0]   acc,
  input  logic signed [2*BIT_WIDTH-1:0] prod,
  output logic [BIT_WIDTH-1:0]          result,
  output logic                          ovf,
  output logic                          unf
);

  localparam int W  = BIT_WIDTH;
  localparam int PW = 2 * BIT_WIDTH;
  localparam int SH = $clog2(BIT_WIDTH);
  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  // Sign-extended product of sign-extended operands: low PW bits are the exact signed product.
  assign product = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};

  logic signed [PW-1:0] shifted;
  logic [PW:0]          add_w, sub_w, mul_w, mac_w;
  logic [SH-1:0]        shamt;

  assign shifted = prod >>> frac;
  assign shamt   = b[SH-1:0];
  assign add_w   = {{(W+1){a[W-1]}}, a} + {{(W+1){b[W-1]}}, b};
  assign sub_w   = {{(W+1){a[W-1]}}, a} - {{(W+1){b[W-1]}}, b};
  assign mul_w   = {shifted[PW-1], shifted};
  assign mac_w   = {shifted[PW-1], shifted} + {{(W+1){acc[W-1]}}, acc};

  // Returns {ovf, unf, value}; a value fits when all bits above the lane's sign bit agree.
  function automatic logic [W+1:0] saturate(input logic [PW:0] v);
    if (v[PW:W-1] == '0 || v[PW:W-1] == '1) return {2'b00, v[W-1:0]};
    else if (!v[PW])                        return {2'b10, SAT_MAX};
    else                                    return {2'b01, SAT_MIN};
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result = a;
    ovf    = 1'b0;
    unf    = 1'b0;
    case (fn)
      FUNCTION_BITS'(OP_ADD): {ovf, unf, result} = saturate(add_w);
      FUNCTION_BITS'(OP_SUB): {ovf, unf, result} = saturate(sub_w);
      FUNCTION_BITS'(OP_MUL): {ovf, unf, result} = saturate(mul_w);
      FUNCTION_BITS'(OP_MAC): {ovf, unf, result} = saturate(mac_w);
      FUNCTION_BITS'(OP_MAX): result = (a > b) ? a : b;
      FUNCTION_BITS'(OP_MIN): result = (a < b) ? a : b;
      FUNCTION_BITS'(OP_ASR): result = a >>> shamt;
      FUNCTION_BITS'(OP_SHL): result = a << shamt;
      FUNCTION_BITS'(OP_NOT): result = ~a;
      FUNCTION_BITS'(OP_AND): result = a & b;
      FUNCTION_BITS'(OP_OR):  result = a | b;
      FUNCTION_BITS'(OP_XOR): result = a ^ b;
      default:                result = a;
    endcase
    if (!en) begin
      result = '0;
      ovf    = 1'b0;
      unf    = 1'b0;
    end
  end

endmodule

// File: rtl/simd_arith_pipe.sv
// Two-stage SIMD saturating arithmetic pipeline with valid/ready handshakes and
// sticky per-lane saturation flags. Stage 1 holds operands and product, stage 2 the result.
module simd_arith_pipe
  import simd_arith_pipe_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FUNCTION_BITS-1:0]     fn,
  input  logic [7:0]                   frac_bits,
  input  logic [LANES*BIT_WIDTH-1:0]   data_a,
  input  logic [LANES*BIT_WIDTH-1:0]   data_b,
  input  logic [LANES*BIT_WIDTH-1:0]   data_acc,
  input  logic [LANES-1:0]             lane_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*BIT_WIDTH-1:0]   data_out,
  input  logic                         flag_clr,
  output logic [LANES-1:0]             ovf_flag,
  output logic [LANES-1:0]             unf_flag
);

  localparam int W  = BIT_WIDTH;
  localparam int PW = 2 * BIT_WIDTH;

  logic                     s1_valid;
  logic                     s2_ready;
  logic                     take;
  logic                     advance;
  logic [7:0]               frac_clamped;
  logic [FUNCTION_BITS-1:0] s1_fn;
  logic [7:0]               s1_frac;
  logic [LANES-1:0]         s1_mask;
  logic [LANES*W-1:0]       s1_a, s1_b, s1_acc;
  logic [LANES*PW-1:0]      product, s1_prod;
  logic [LANES*W-1:0]       result;
  logic [LANES-1:0]         lane_ovf, lane_unf;

  assign s2_ready     = !out_valid || out_ready;
  assign in_ready     = !s1_valid || s2_ready;
  assign take         = in_valid && in_ready;
  assign advance      = s1_valid && s2_ready;
  assign frac_clamped = (frac_bits >= 8'(W)) ? 8'(W - 1) : frac_bits;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_lane_sat #(
      .BIT_WIDTH    (W),
      .FUNCTION_BITS(FUNCTION_BITS)
    ) u_lane (
      .mul_a  (data_a[i*W +: W]),
      .mul_b  (data_b[i*W +: W]),
      .product(product[i*PW +: PW]),
      .fn     (s1_fn),
      .frac   (s1_frac),
      .en     (s1_mask[i]),
      .a      (s1_a[i*W +: W]),
      .b      (s1_b[i*W +: W]),
      .acc    (s1_acc[i*W +: W]),
      .prod   (s1_prod[i*PW +: PW]),
      .result (result[i*W +: W]),
      .ovf    (lane_ovf[i]),
      .unf    (lane_unf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)         s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  // NOTE: stage-1 payload registers carry no reset; s1_valid alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (take) begin
      s1_fn   <= fn;
      s1_frac <= frac_clamped;
      s1_mask <= lane_mask;
      s1_a    <= data_a;
      s1_b    <= data_b;
      s1_acc  <= data_acc;
      s1_prod <= product;
    end
  end

  // A saturation arriving in the same cycle as flag_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      ovf_flag  <= '0;
      unf_flag  <= '0;
    end else begin
      if (s2_ready) out_valid <= s1_valid;
      if (advance)  data_out  <= result;
      ovf_flag <= (flag_clr ? '0 : ovf_flag) | (advance ? lane_ovf : '0);
      unf_flag <= (flag_clr ? '0 : unf_flag) | (advance ? lane_unf : '0);
    end
  end

endmodule

// File: tb/tb_simd_arith_pipe.sv
// Directed testbench for simd_arith_pipe (LANES=4, BIT_WIDTH=16) with hand-computed expectations.
module tb_simd_arith_pipe;

  localparam int LANES = 4;
  localparam int BW    = 16;
  localparam int FB    = 4;

  localparam logic [3:0] F_ADD = 4'b0000, F_SUB = 4'b0001, F_MUL = 4'b0010, F_MAC = 4'b0011;
  localparam logic [3:0] F_MAX = 4'b0101, F_MIN = 4'b0110, F_ASR = 4'b0111, F_SHL = 4'b1000;
  localparam logic [3:0] F_NOT = 4'b1100, F_AND = 4'b1101, F_OR  = 4'b1110, F_XOR = 4'b1111;
  localparam logic [3:0] F_PASS = 4'b0100, F_PASS2 = 4'b1001;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [FB-1:0]         fn;
  logic [7:0]            frac_bits;
  logic [LANES*BW-1:0]   data_a, data_b, data_acc;
  logic [LANES-1:0]      lane_mask;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*BW-1:0]   data_out;
  logic                  flag_clr;
  logic [LANES-1:0]      ovf_flag, unf_flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  simd_arith_pipe #(
    .LANES        (LANES),
    .BIT_WIDTH    (BW),
    .FUNCTION_BITS(FB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fn       (fn),
    .frac_bits(frac_bits),
    .data_a   (data_a),
    .data_b   (data_b),
    .data_acc (data_acc),
    .lane_mask(lane_mask),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .flag_clr (flag_clr),
    .ovf_flag (ovf_flag),
    .unf_flag (unf_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic clear_flags();
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
  endtask

  // Send one beat into an idle pipeline, check it is accepted, measure latency, check result.
  task automatic beat(input string tag, input logic [3:0] f, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] acc, input logic [3:0] m,
                      input logic [7:0] fr, input logic [63:0] exp);
    int n;
    @(negedge clk);
    fn = f; data_a = a; data_b = b; data_acc = acc; lane_mask = m; frac_bits = fr;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    n = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd2);
    check({tag, "_data"}, data_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, recv, c;
    bit drop_checked;
    logic [15:0] v;
    logic [63:0] exp_q [4];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    fn = '0; frac_bits = '0; data_a = '0; data_b = '0; data_acc = '0; lane_mask = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_ovf", 64'(ovf_flag), 64'd0);
    check("rst_unf", 64'(unf_flag), 64'd0);
    reset = 1'b0;

    // Saturating add/sub with mixed lanes.
    beat("add_sat", F_ADD, {16'h0001, 16'h8000, 16'h1234, 16'h7FF0},
         {16'h0002, 16'hFFFF, 16'h0020, 16'h0020}, '0, 4'b1111, 8'd0,
         {16'h0003, 16'h8000, 16'h1254, 16'h7FFF});
    check("add_sat_ovf", 64'(ovf_flag), 64'h1);
    check("add_sat_unf", 64'(unf_flag), 64'h4);
    beat("add_small", F_ADD, {4{16'h0001}}, {4{16'h0002}}, '0, 4'b1111, 8'd0, {4{16'h0003}});
    check("sticky_ovf", 64'(ovf_flag), 64'h1);
    check("sticky_unf", 64'(unf_flag), 64'h4);
    clear_flags();
    check("clr_ovf", 64'(ovf_flag), 64'h0);
    check("clr_unf", 64'(unf_flag), 64'h0);

    beat("sub_sat", F_SUB, {16'h0100, 16'h0005, 16'h7FFF, 16'h8000},
         {16'h0001, 16'h0007, 16'hFFFF, 16'h0001}, '0, 4'b1111, 8'd0,
         {16'h00FF, 16'hFFFE, 16'h7FFF, 16'h8000});
    check("sub_ovf", 64'(ovf_flag), 64'h2);
    check("sub_unf", 64'(unf_flag), 64'h1);
    clear_flags();

    // Fixed-point multiply, including a negative product truncated toward minus infinity.
    beat("mul", F_MUL, {16'hFFFF, 16'hFF00, 16'h7F00, 16'h0180},
         {16'h0001, 16'h0200, 16'h0200, 16'h0200}, '0, 4'b1111, 8'd8,
         {16'hFFFF, 16'hFE00, 16'h7FFF, 16'h0300});
    check("mul_ovf", 64'(ovf_flag), 64'h2);
    check("mul_unf", 64'(unf_flag), 64'h0);
    beat("mul_frac200", F_MUL, {4{16'h4000}}, {4{16'h4000}}, '0, 4'b1111, 8'd200, {4{16'h2000}});
    beat("mul_frac16", F_MUL, {4{16'h4000}}, {4{16'h4000}}, '0, 4'b1111, 8'd16, {4{16'h2000}});
    clear_flags();

    // MAC: underflow, overflow, normal, and a product that only fits after adding acc.
    beat("mac", F_MAC, {16'h7F00, 16'h0100, 16'h0200, 16'hFFFF},
         {16'h0200, 16'h0100, 16'h0300, 16'h0100}, {16'h8000, 16'h7FFF, 16'h0010, 16'h8000},
         4'b1111, 8'd8, {16'h7E00, 16'h7FFF, 16'h0610, 16'h8000});
    check("mac_ovf", 64'(ovf_flag), 64'h4);
    check("mac_unf", 64'(unf_flag), 64'h1);
    clear_flags();

    beat("max", F_MAX, {16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF},
         {16'h0003, 16'h0001, 16'h7FFF, 16'h8000}, '0, 4'b1111, 8'd0,
         {16'h0005, 16'h0001, 16'h7FFF, 16'h7FFF});
    beat("min", F_MIN, {16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF},
         {16'h0003, 16'h0001, 16'h7FFF, 16'h8000}, '0, 4'b1111, 8'd0,
         {16'h0003, 16'hFFFF, 16'h8000, 16'h8000});
    beat("asr", F_ASR, {16'h7FFF, 16'hF000, 16'h1234, 16'h8000},
         {16'h000F, 16'h0010, 16'h0013, 16'h0004}, '0, 4'b1111, 8'd0,
         {16'h0000, 16'hF000, 16'h0246, 16'hF800});
    beat("shl", F_SHL, {16'h7FFF, 16'hF000, 16'h1234, 16'h8000},
         {16'h000F, 16'h0010, 16'h0013, 16'h0004}, '0, 4'b1111, 8'd0,
         {16'h8000, 16'hF000, 16'h91A0, 16'h0000});
    check("shift_ovf", 64'(ovf_flag), 64'h0);
    check("shift_unf", 64'(unf_flag), 64'h0);
    beat("not", F_NOT, {4{16'h00FF}}, {4{16'h1234}}, '0, 4'b1111, 8'd0, {4{16'hFF00}});
    beat("and", F_AND, {4{16'h0F0F}}, {4{16'h00FF}}, '0, 4'b1111, 8'd0, {4{16'h000F}});
    beat("or", F_OR, {4{16'h0F0F}}, {4{16'h00FF}}, '0, 4'b1111, 8'd0, {4{16'h0FFF}});
    beat("xor", F_XOR, {4{16'h0F0F}}, {4{16'h00FF}}, '0, 4'b1111, 8'd0, {4{16'h0FF0}});
    beat("pass4", F_PASS, {4{16'hA5C3}}, {4{16'h00FF}}, '0, 4'b1111, 8'd0, {4{16'hA5C3}});
    beat("pass9", F_PASS2, {4{16'h5A3C}}, {4{16'h00FF}}, '0, 4'b1111, 8'd0, {4{16'h5A3C}});

    // Masked lanes produce zero and never flag.
    beat("mask", F_ADD, {4{16'h7FF0}}, {4{16'h0020}}, '0, 4'b0101, 8'd0,
         {16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF});
    check("mask_ovf", 64'(ovf_flag), 64'h5);
    check("mask_unf", 64'(unf_flag), 64'h0);
    clear_flags();

    // flag_clr in the same cycle a new saturation enters stage 2.
    beat("pre_unf", F_ADD, {16'h0, 16'h0, 16'h8000, 16'h0}, {16'h0, 16'h0, 16'hFFFF, 16'h0},
         '0, 4'b1111, 8'd0, {16'h0, 16'h0, 16'h8000, 16'h0});
    check("pre_unf_flag", 64'(unf_flag), 64'h2);
    @(negedge clk);
    fn = F_ADD; data_a = {16'h0, 16'h0, 16'h0, 16'h7FF0}; data_b = {16'h0, 16'h0, 16'h0, 16'h0020};
    lane_mask = 4'b1111; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    check("clr_race_out_valid", 64'(out_valid), 64'd1);
    check("clr_race_data", data_out, {16'h0, 16'h0, 16'h0, 16'h7FFF});
    check("clr_race_ovf", 64'(ovf_flag), 64'h1);
    check("clr_race_unf", 64'(unf_flag), 64'h0);
    clear_flags();

    // Backpressure: four back-to-back beats, sink stalled for the first cycles.
    for (int k = 0; k < 4; k++) exp_q[k] = {4{16'(16'h0101 + k)}};
    sent = 0; recv = 0; drop_checked = 1'b0;
    fn = F_ADD; lane_mask = 4'b1111; data_b = {4{16'h0100}};
    for (c = 0; c < 40 && recv < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (sent < 4);
      v = 16'(sent + 1);
      data_a = {4{v}};
      #1;
      if (sent == 2 && !drop_checked) begin
        check("bp_ready_drop", 64'(in_ready), 64'd0);
        drop_checked = 1'b1;
      end
      if (out_valid && !out_ready) check("bp_hold", data_out, exp_q[recv]);
      if (out_valid && out_ready) begin
        check($sformatf("bp_beat%0d", recv), data_out, exp_q[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    in_valid = 1'b0;
    check("bp_received", 64'(recv), 64'd4);

    // Reset with both stages full discards everything.
    @(negedge clk);
    out_ready = 1'b0; fn = F_ADD; data_a = {4{16'h7FF0}}; data_b = {4{16'h0020}}; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_a = {4{16'h0010}};
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ovf", 64'(ovf_flag), 64'h0);
    check("mid_rst_unf", 64'(unf_flag), 64'h0);
    check("mid_rst_data", data_out, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    beat("post_rst", F_ADD, {4{16'h0001}}, {4{16'h0002}}, '0, 4'b1111, 8'd0, {4{16'h0003}});

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
